// File: rtl/stream_mux_if.sv
// -----------------------------------------------------------------------------
// stream_mux_if -- bundle of the N-input / 1-output valid-ready stream signals
// served by stream_mux.
//
// Signals
//   in_data   [NUM_CH*DATA_W] channel i at bits [i*DATA_W +: DATA_W]
//   in_valid  [NUM_CH]        per-channel beat valid
//   in_last   [NUM_CH]        per-channel end-of-packet, qualified by in_valid
//   in_ready  [NUM_CH]        per-channel accept (driven by the mux)
//   out_data  [DATA_W]        selected beat
//   out_valid, out_last       output beat qualifiers
//   out_ch    [SEL_W]         source channel of the current output beat
//   out_ready                 downstream accept
//
// Modports
//   slave  : the multiplexer itself
//   master : the surrounding sources and sink
// -----------------------------------------------------------------------------
interface stream_mux_if #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
);
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_ch
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_ch
  );
endinterface

// File: rtl/stream_mux.sv
// -----------------------------------------------------------------------------
// stream_mux -- packet-granular N:1 stream multiplexer.
//
// A channel is granted in IDLE (one decision cycle), then the mux stays LOCKED
// on it until a beat carrying last is accepted. Output is a single register
// stage with full throughput (one beat per cycle).
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   sel    : requested channel in fixed mode
//   mode   : 0 = fixed select, 1 = round-robin (only with STREAM_MUX_RR_EN)
//   bus    : stream_mux_if.slave, input channels and output stream
//
// Configuration
//   STREAM_MUX_RR_EN : when defined, mode=1 selects round-robin arbitration
//                      starting after the last granted channel. When undefined
//                      mode is ignored and fixed select is always used.
// -----------------------------------------------------------------------------
module stream_mux #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic             mode,
  stream_mux_if.slave      bus
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SEL_W-1:0]  r_g;
  logic [SEL_W-1:0]  w_g_nxt;

  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic [SEL_W-1:0]  r_out_ch;

  logic [NUM_CH-1:0] w_in_ready;
  logic [DATA_W-1:0] w_g_data;
  logic              w_g_last;
  logic              w_sel_ok;
  logic              w_acc;

  // Constant-index muxes: an out-of-range sel simply matches no channel,
  // which is what keeps sel >= NUM_CH from ever granting.
  always_comb begin
    w_g_data   = '0;
    w_g_last   = 1'b0;
    w_sel_ok   = 1'b0;
    w_in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_g == SEL_W'(i)) begin
        w_g_data = bus.in_data[i*DATA_W +: DATA_W];
        w_g_last = bus.in_last[i];
        if (r_state == LOCKED) begin
          w_in_ready[i] = !r_out_valid || bus.out_ready;
        end
      end
      if (sel == SEL_W'(i) && bus.in_valid[i]) begin
        w_sel_ok = 1'b1;
      end
    end
  end

  // Only the granted bit of w_in_ready can be set.
  assign w_acc = |(bus.in_valid & w_in_ready);

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] r_last_g;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_rr_hi_found;
  logic [SEL_W-1:0] w_rr_hi_idx;
  logic [SEL_W-1:0] w_rr_lo_idx;

  // Wrapping scan from last_g+1: the lowest requester above last_g wins;
  // if there is none, the lowest requester overall (the wrapped part) wins.
  always_comb begin
    w_rr_found    = 1'b0;
    w_rr_hi_found = 1'b0;
    w_rr_hi_idx   = '0;
    w_rr_lo_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        w_rr_found  = 1'b1;
        w_rr_lo_idx = SEL_W'(i);
        if (SEL_W'(i) > r_last_g) begin
          w_rr_hi_found = 1'b1;
          w_rr_hi_idx   = SEL_W'(i);
        end
      end
    end
    w_rr_idx = w_rr_hi_found ? w_rr_hi_idx : w_rr_lo_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_g <= SEL_W'(NUM_CH - 1);
    end else if (r_state == LOCKED && w_acc && w_g_last) begin
      r_last_g <= r_g;
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    case (r_state)
      IDLE: begin
`ifdef STREAM_MUX_RR_EN
        if (mode) begin
          if (w_rr_found) begin
            w_state_nxt = LOCKED;
            w_g_nxt     = w_rr_idx;
          end
        end else if (w_sel_ok) begin
          w_state_nxt = LOCKED;
          w_g_nxt     = sel;
        end
`else
        if (w_sel_ok) begin
          w_state_nxt = LOCKED;
          w_g_nxt     = sel;
        end
`endif
      end
      LOCKED: begin
        if (w_acc && w_g_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_g     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
    end
  end

  // Output register: a new beat overwrites the held one whenever the input
  // side is allowed to accept, which includes the simultaneous-drain case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_g_last;
      r_out_data  <= w_g_data;
      r_out_ch    <= r_g;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux.sv
// -----------------------------------------------------------------------------
// tb_stream_mux -- directed self-checking bench for stream_mux.
// An 8-channel instance carries most scenarios; a 6-channel instance covers an
// out-of-range select.
// -----------------------------------------------------------------------------
module tb_stream_mux;
  localparam int NC  = 8;
  localparam int NC6 = 6;
  localparam int DW  = 8;
  localparam int SW  = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] sel   = '0;
  logic          mode  = 1'b0;
  logic [SW-1:0] sel6  = '0;
  logic          mode6 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  stream_mux_if #(.NUM_CH(NC),  .DATA_W(DW), .SEL_W(SW)) b8 ();
  stream_mux_if #(.NUM_CH(NC6), .DATA_W(DW), .SEL_W(SW)) b6 ();

  stream_mux #(.NUM_CH(NC), .DATA_W(DW), .SEL_W(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sel  (sel),
    .mode (mode),
    .bus  (b8.slave)
  );

  stream_mux #(.NUM_CH(NC6), .DATA_W(DW), .SEL_W(SW)) dut6 (
    .clk  (clk),
    .rst_n(rst_n),
    .sel  (sel6),
    .mode (mode6),
    .bus  (b6.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic v, input logic [DW-1:0] d, input logic l);
    b8.in_valid[ch]          = v;
    b8.in_data[ch*DW +: DW]  = d;
    b8.in_last[ch]           = l;
  endtask

  task automatic clear_inputs;
    b8.in_valid = '0;
    b8.in_data  = '0;
    b8.in_last  = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    // rst_n is low here; valids are high to show in_ready is forced off
    b8.in_valid  = '1;
    b8.out_ready = 1'b1;
    tick;
    n_checks++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h want 0", b8.out_valid); end
    n_checks++; if (b8.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %0h want 0", b8.out_data); end
    n_checks++; if (b8.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %0h want 0", b8.out_last); end
    n_checks++; if (b8.out_ch !== 3'd0) begin n_fail++; $display("FAIL reset_out_ch: got %0h want 0", b8.out_ch); end
    n_checks++; if (b8.in_ready !== 8'h00) begin n_fail++; $display("FAIL reset_in_ready: got %0h want 0", b8.in_ready); end
    n_checks++; if (b6.in_ready !== 6'h00) begin n_fail++; $display("FAIL reset_in_ready6: got %0h want 0", b6.in_ready); end
    clear_inputs;
  endtask

  task automatic test_fixed;
    int nout = 0;
    int nin = 0;
    int first = -1;
    logic acc;
    do_reset;
    clear_inputs;
    mode = 1'b0;
    sel = 3'd3;
    b8.out_ready = 1'b1;
    drive(3, 1'b1, 8'h31, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      acc = b8.in_valid[3] && b8.in_ready[3];
      tick;
      if (acc) begin
        nin++;
        if (nin == 4) drive(3, 1'b0, 8'h00, 1'b0);
        else drive(3, 1'b1, 8'(8'h31 + nin), nin == 3);
        if (nin == 4) begin
          n_checks++;
          if (b8.in_ready !== 8'h00) begin n_fail++; $display("FAIL fixed_ready_after_last: got %0h want 0", b8.in_ready); end
        end
      end
      if (b8.out_valid && b8.out_ready) begin
        if (first < 0) first = c;
        n_checks++; if (b8.out_data !== 8'(8'h31 + nout)) begin n_fail++; $display("FAIL fixed_data: got %0h want %0h", b8.out_data, 8'(8'h31 + nout)); end
        n_checks++; if (b8.out_ch !== 3'd3) begin n_fail++; $display("FAIL fixed_ch: got %0d want 3", b8.out_ch); end
        n_checks++; if (b8.out_last !== (nout == 3)) begin n_fail++; $display("FAIL fixed_last: beat %0d got %0b", nout, b8.out_last); end
        nout++;
      end
    end
    n_checks++; if (nout != 4) begin n_fail++; $display("FAIL fixed_count: got %0d want 4", nout); end
    n_checks++; if (first != 2) begin n_fail++; $display("FAIL fixed_latency: got %0d want 2", first); end
  endtask

  task automatic test_round_robin;
    int nout = 0;
    do_reset;
    clear_inputs;
    b8.out_ready = 1'b1;
    mode = 1'b1;
`ifdef STREAM_MUX_RR_EN
    for (int i = 0; i < NC; i++) drive(i, 1'b1, 8'(8'hA0 + i), 1'b1);
    for (int c = 1; c <= 40 && nout < 9; c++) begin
      tick;
      if (b8.out_valid) begin
        n_checks++; if (b8.out_ch !== SW'(nout % 8)) begin n_fail++; $display("FAIL rr_order: beat %0d got ch %0d want %0d", nout, b8.out_ch, nout % 8); end
        n_checks++; if (b8.out_data !== 8'(8'hA0 + nout % 8)) begin n_fail++; $display("FAIL rr_data: got %0h want %0h", b8.out_data, 8'(8'hA0 + nout % 8)); end
        nout++;
      end
    end
    n_checks++; if (nout != 9) begin n_fail++; $display("FAIL rr_count: got %0d want 9", nout); end
`else
    // mode is ignored: the fixed select (ch5) wins although ch0 also requests
    sel = 3'd5;
    drive(0, 1'b1, 8'hA0, 1'b1);
    drive(5, 1'b1, 8'hA5, 1'b1);
    for (int c = 1; c <= 10 && nout < 1; c++) begin
      tick;
      if (b8.out_valid) begin
        n_checks++; if (b8.out_ch !== 3'd5) begin n_fail++; $display("FAIL mode_ignored_ch: got %0d want 5", b8.out_ch); end
        n_checks++; if (b8.out_data !== 8'hA5) begin n_fail++; $display("FAIL mode_ignored_data: got %0h want a5", b8.out_data); end
        nout++;
      end
    end
    n_checks++; if (nout != 1) begin n_fail++; $display("FAIL mode_ignored_count: got %0d want 1", nout); end
`endif
    mode = 1'b0;
    clear_inputs;
  endtask

  task automatic test_backpressure;
    int nout = 0;
    int nin = 0;
    logic acc;
    do_reset;
    clear_inputs;
    sel = 3'd1;
    drive(1, 1'b1, 8'h11, 1'b0);
    for (int c = 1; c <= 30; c++) begin
      b8.out_ready = !(c >= 5 && c <= 7);
      #1;
      acc = b8.in_valid[1] && b8.in_ready[1];
      if (b8.out_valid && !b8.out_ready) begin
        n_checks++; if (b8.in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %0b want 0", c, b8.in_ready[1]); end
        n_checks++; if (b8.out_data !== 8'(8'h11 + nout)) begin n_fail++; $display("FAIL bp_hold: got %0h want %0h", b8.out_data, 8'(8'h11 + nout)); end
      end
      if (b8.out_valid && b8.out_ready) begin
        n_checks++; if (b8.out_data !== 8'(8'h11 + nout)) begin n_fail++; $display("FAIL bp_data: got %0h want %0h", b8.out_data, 8'(8'h11 + nout)); end
        n_checks++; if (b8.out_last !== (nout == 5)) begin n_fail++; $display("FAIL bp_last: beat %0d got %0b", nout, b8.out_last); end
        nout++;
      end
      tick;
      if (acc) begin
        nin++;
        if (nin == 6) drive(1, 1'b0, 8'h00, 1'b0);
        else drive(1, 1'b1, 8'(8'h11 + nin), nin == 5);
      end
    end
    n_checks++; if (nout != 6) begin n_fail++; $display("FAIL bp_out_count: got %0d want 6", nout); end
    n_checks++; if (nin != 6) begin n_fail++; $display("FAIL bp_in_count: got %0d want 6", nin); end
  endtask

  task automatic test_sel_change;
    logic [7:0] exp_d [4] = '{8'h21, 8'h22, 8'h23, 8'h51};
    logic [2:0] exp_c [4] = '{3'd2, 3'd2, 3'd2, 3'd5};
    int nout = 0;
    int nin2 = 0;
    logic acc2, acc5;
    do_reset;
    clear_inputs;
    sel = 3'd2;
    b8.out_ready = 1'b1;
    drive(2, 1'b1, 8'h21, 1'b0);
    drive(5, 1'b1, 8'h51, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      acc2 = b8.in_valid[2] && b8.in_ready[2];
      acc5 = b8.in_valid[5] && b8.in_ready[5];
      if (nin2 < 3) begin
        n_checks++; if (b8.in_ready[5] !== 1'b0) begin n_fail++; $display("FAIL selchg_early_ch5: cycle %0d got %0b want 0", c, b8.in_ready[5]); end
      end
      if (b8.out_valid && b8.out_ready) begin
        if (nout < 4) begin
          n_checks++; if (b8.out_data !== exp_d[nout] || b8.out_ch !== exp_c[nout]) begin
            n_fail++; $display("FAIL selchg_seq: beat %0d got %0h/ch%0d want %0h/ch%0d", nout, b8.out_data, b8.out_ch, exp_d[nout], exp_c[nout]);
          end
        end
        nout++;
      end
      tick;
      if (acc2) begin
        nin2++;
        if (nin2 == 1) sel = 3'd5;
        if (nin2 == 3) drive(2, 1'b0, 8'h00, 1'b0);
        else drive(2, 1'b1, 8'(8'h21 + nin2), nin2 == 2);
      end
      if (acc5) drive(5, 1'b0, 8'h00, 1'b0);
    end
    n_checks++; if (nout != 4) begin n_fail++; $display("FAIL selchg_count: got %0d want 4", nout); end
  endtask

  task automatic test_sel_oob;
    sel6 = 3'b111;
    b6.in_valid  = '1;
    b6.in_last   = '1;
    for (int i = 0; i < NC6; i++) b6.in_data[i*DW +: DW] = 8'(8'h60 + i);
    b6.out_ready = 1'b1;
    do_reset;
    for (int c = 1; c <= 6; c++) begin
      tick;
      n_checks++; if (b6.in_ready !== 6'h00) begin n_fail++; $display("FAIL oob_in_ready: got %0h want 0", b6.in_ready); end
      n_checks++; if (b6.out_valid !== 1'b0) begin n_fail++; $display("FAIL oob_out_valid: got %0b want 0", b6.out_valid); end
    end
    sel6 = 3'd4;
    tick;
    n_checks++; if (b6.in_ready !== 6'b010000) begin n_fail++; $display("FAIL oob_then_valid_grant: got %0h want 10", b6.in_ready); end
    tick;
    n_checks++; if (b6.out_valid !== 1'b1 || b6.out_ch !== 3'd4 || b6.out_data !== 8'h64) begin
      n_fail++; $display("FAIL oob_then_valid_beat: got v%0b ch%0d %0h want v1 ch4 64", b6.out_valid, b6.out_ch, b6.out_data);
    end
    b6.in_valid = '0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    clear_inputs;
    sel = 3'd3;
    b8.out_ready = 1'b0;
    drive(3, 1'b1, 8'h35, 1'b0);
    tick;
    tick;
    n_checks++; if (b8.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_held_beat: got %0b want 1", b8.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async_valid: got %0b want 0", b8.out_valid); end
    n_checks++; if (b8.in_ready !== 8'h00) begin n_fail++; $display("FAIL rmid_async_ready: got %0h want 0", b8.in_ready); end
    n_checks++; if (b8.out_data !== 8'h00) begin n_fail++; $display("FAIL rmid_async_data: got %0h want 0", b8.out_data); end
    drive(3, 1'b1, 8'h3A, 1'b1);
    b8.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    n_checks++; if (b8.out_valid !== 1'b0 || b8.in_ready !== 8'h08) begin
      n_fail++; $display("FAIL rmid_regrant: got v%0b rdy%0h want v0 rdy08", b8.out_valid, b8.in_ready);
    end
    tick;
    n_checks++; if (b8.out_valid !== 1'b1 || b8.out_data !== 8'h3A || b8.out_ch !== 3'd3 || b8.out_last !== 1'b1) begin
      n_fail++; $display("FAIL rmid_new_beat: got v%0b %0h ch%0d l%0b want v1 3a ch3 l1", b8.out_valid, b8.out_data, b8.out_ch, b8.out_last);
    end
    drive(3, 1'b0, 8'h00, 1'b0);
    tick;
    n_checks++; if (b8.out_valid !== 1'b0 || b8.in_ready !== 8'h00) begin
      n_fail++; $display("FAIL rmid_drain: got v%0b rdy%0h want v0 rdy0", b8.out_valid, b8.in_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs;
    b8.out_ready = 1'b0;
    b6.in_valid  = '0;
    b6.in_data   = '0;
    b6.in_last   = '0;
    b6.out_ready = 1'b0;
    rst_n = 1'b0;
    tick;
    test_reset;
    rst_n = 1'b1;
    tick;
    test_fixed;
    test_round_robin;
    test_backpressure;
    test_sel_change;
    test_sel_oob;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
